// File: rtl/mac_engine.sv
// mac_engine: sequential matrix multiply C = A * X, one multiply-accumulate per
// cycle. Operands come from external synchronous-read memories (one cycle of read
// latency). Each result is presented on sum with a one-cycle active-low web strobe.
module mac_engine #(
  parameter int ROWS = 4,
  parameter int COLS = 8,
  parameter int K    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  in_addr,
  input  logic [7:0]  in_data,
  output logic [3:0]  coef_addr,
  input  logic [6:0]  coef_data,
  output logic [19:0] sum,
  output logic        web,
  output logic        busy,
  output logic        done
);

  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int JW = (COLS > 1) ? $clog2(COLS) : 1;
  // The CALC cycle counter runs 0..K, so it needs room for K itself.
  localparam int KW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [19:0]   acc_q, acc_d;
  logic [19:0]   sum_q, sum_d;
  logic          web_q, web_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [4:0]    in_addr_q, in_addr_d;
  logic [3:0]    coef_addr_q, coef_addr_d;

  logic [14:0]   prod;
  logic [19:0]   acc_add;

  // X[k][j] lives at k*COLS+j.
  function automatic logic [4:0] x_addr(input logic [KW-1:0] k, input logic [JW-1:0] j);
    return 5'(32'(k) * 32'(COLS) + 32'(j));
  endfunction

  // A[i][k] lives at i*K+k.
  function automatic logic [3:0] a_addr(input logic [IW-1:0] i, input logic [KW-1:0] k);
    return 4'(32'(i) * 32'(K) + 32'(k));
  endfunction

  assign prod    = 15'(in_data) * 15'(coef_data);
  assign acc_add = acc_q + {5'd0, prod};

  // Next-state and datapath control. Addresses are registered, so they are loaded
  // one edge ahead of the CALC cycle that presents them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    web_d       = 1'b1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_addr_d   = in_addr_q;
    coef_addr_d = coef_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CALC;
          cnt_d       = '0;
          i_d         = '0;
          j_d         = '0;
          acc_d       = '0;
          busy_d      = 1'b1;
          in_addr_d   = x_addr('0, '0);
          coef_addr_d = a_addr('0, '0);
        end
      end
      CALC: begin
        // Data for k=cnt-1 arrives in cycle cnt; cycle 0 has nothing to add yet.
        if (cnt_q != '0) begin
          acc_d = acc_add;
        end
        if (cnt_q == KW'(K)) begin
          state_d = WRITE;
          sum_d   = acc_add;
          web_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + KW'(1);
          if (cnt_q < KW'(K - 1)) begin
            in_addr_d   = x_addr(cnt_q + KW'(1), j_q);
            coef_addr_d = a_addr(i_q, cnt_q + KW'(1));
          end
        end
      end
      WRITE: begin
        cnt_d = '0;
        acc_d = '0;
        if (j_q != JW'(COLS - 1)) begin
          state_d     = CALC;
          j_d         = j_q + JW'(1);
          in_addr_d   = x_addr('0, j_q + JW'(1));
          coef_addr_d = a_addr(i_q, '0);
        end else if (i_q != IW'(ROWS - 1)) begin
          state_d     = CALC;
          j_d         = '0;
          i_d         = i_q + IW'(1);
          in_addr_d   = x_addr('0, '0);
          coef_addr_d = a_addr(i_q + IW'(1), '0);
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any run in progress immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      web_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_addr_q   <= '0;
      coef_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      web_q       <= web_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_addr_q   <= in_addr_d;
      coef_addr_q <= coef_addr_d;
    end
  end

  assign in_addr   = in_addr_q;
  assign coef_addr = coef_addr_q;
  assign sum       = sum_q;
  assign web       = web_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mac_engine.sv
// tb_mac_engine: directed runs of mac_engine against synchronous-read memory
// models, with hand-computed expected sums, timing and address checks.
module tb_mac_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  in_addr;
  logic [7:0]  in_data;
  logic [3:0]  coef_addr;
  logic [6:0]  coef_data;
  logic [19:0] sum;
  logic        web;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  logic [6:0] a_mem [16];
  logic [7:0] x_mem [32];

  mac_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .sum       (sum),
    .web       (web),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    in_data   <= x_mem[in_addr];
    coef_data <= a_mem[coef_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0: all ones, 1: A=127 X=255, 2: A identity, X[n]=n
  task automatic load(input int mode);
    for (int n = 0; n < 16; n++) begin
      case (mode)
        0:       a_mem[n] = 7'd1;
        1:       a_mem[n] = 7'd127;
        default: a_mem[n] = ((n / 4) == (n % 4)) ? 7'd1 : 7'd0;
      endcase
    end
    for (int n = 0; n < 32; n++) begin
      case (mode)
        0:       x_mem[n] = 8'd1;
        1:       x_mem[n] = 8'd255;
        default: x_mem[n] = 8'(n);
      endcase
    end
  endtask

  // One run from a start pulse. Iteration t observes the state after the t-th
  // edge following the edge that sampled start. exp_mode 1 expects sum=index.
  task automatic run(input string name, input int exp_mode, input int cval,
                     input int restart_at, input int abort_res, input bit chk_addr);
    int nstrobe = 0;
    int ndone = 0;
    int done_t = -1;
    int last_t = -1;
    bit aborted = 1'b0;
    logic [31:0] exp;
    start = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      start = (t == restart_at);
      if (t == 0) check({name, "_busy_start"}, busy, 1);
      if (abort_res >= 0 && t == 6 * abort_res + 2) begin
        rst = 1'b0;
        #1;
        check({name, "_rst_web"}, web, 1);
        check({name, "_rst_sum"}, sum, 0);
        check({name, "_rst_busy"}, busy, 0);
        check({name, "_rst_done"}, done, 0);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check({name, "_rst_hold_web"}, web, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        aborted = 1'b1;
        break;
      end
      if (chk_addr && t >= 126 && t <= 129) begin
        check({name, "_coef_addr"}, coef_addr, 32'(8 + (t - 126)));
        check({name, "_in_addr"}, in_addr, 32'(5 + 8 * (t - 126)));
      end
      if (!web) begin
        exp = (exp_mode == 1) ? 32'(nstrobe) : 32'(cval);
        $display("%s result %0d sum=%0d at cycle %0d", name, nstrobe, sum, t);
        check({name, "_sum"}, sum, exp);
        nstrobe++;
        last_t = t;
      end
      if (done) begin
        ndone++;
        if (done_t < 0) done_t = t;
      end
      if (done_t >= 0 && t == done_t + 1) check({name, "_busy_end"}, busy, 0);
      if (done_t >= 0 && t >= done_t + 4) break;
    end
    if (aborted) begin
      check({name, "_strobes_before_abort"}, nstrobe, 9);
    end else begin
      check({name, "_strobes"}, nstrobe, 32);
      check({name, "_done_cycle"}, done_t, 192);
      check({name, "_done_count"}, ndone, 1);
      check({name, "_done_after_last"}, done_t - last_t, 1);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    load(0);
    repeat (3) @(negedge clk);
    check("reset_sum", sum, 0);
    check("reset_web", web, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_in_addr", in_addr, 0);
    check("reset_coef_addr", coef_addr, 0);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_web", web, 1);
      check("idle_busy", busy, 0);
    end
    load(0);
    run("ones", 0, 4, -1, -1, 1'b1);
    load(1);
    run("max", 0, 129540, -1, -1, 1'b0);
    load(2);
    run("ident", 1, 0, -1, -1, 1'b1);
    load(0);
    run("restart", 0, 4, 50, -1, 1'b0);
    load(2);
    run("abort", 1, 0, -1, 9, 1'b0);
    run("after_abort", 1, 0, -1, -1, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
